// File: rtl/fmul_mant_iter.sv
// Iterative shift-and-add unsigned mantissa multiplier. Drives an external
// carry-lookahead adder from registers and folds its sum back into the accumulator.
module fmul_mant_iter #(
  parameter int MANT_W = 24,
  parameter int ACC_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     in_mcand,
  input  logic [MANT_W-1:0]     in_mplier,
  output logic [ACC_W-1:0]      add_op1,
  output logic [ACC_W-1:0]      add_op2,
  input  logic [ACC_W-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   out_prod,
  output logic                  out_ovf
);

  localparam int CNT_W = $clog2(MANT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);
  // Bits of the accumulator that belong to the product; anything above is overflow.
  localparam logic [ACC_W-1:0] LO_MASK = (2 * MANT_W >= ACC_W) ? {ACC_W{1'b1}} :
                                         ((ACC_W'(1) << (2 * MANT_W)) - ACC_W'(1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    mcand_sh_q, mcand_sh_d;
  logic [MANT_W-1:0]   mplier_sh_q, mplier_sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  function automatic logic upper_nonzero(input logic [ACC_W-1:0] v);
    return |(v & ~LO_MASK);
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_sh_d  = mcand_sh_q;
    mplier_sh_d = mplier_sh_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d       = '0;
          mcand_sh_d  = ACC_W'(in_mcand);
          mplier_sh_d = in_mplier;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // The adder result is only meaningful when this multiplier bit is set.
        if (mplier_sh_q[0]) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
        end
        mcand_sh_d  = mcand_sh_q << 1;
        mplier_sh_d = mplier_sh_q >> 1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          ovf_d   = ovf_d | upper_nonzero(acc_d);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_sh_q  <= '0;
      mplier_sh_q <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_sh_q  <= mcand_sh_d;
      mplier_sh_q <= mplier_sh_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign add_op1   = acc_q;
  assign add_op2   = mcand_sh_q;
  assign out_prod  = acc_q[2*MANT_W-1:0];
  assign out_ovf   = ovf_q;

endmodule

// File: doc/fmul_mant_iter.md
Name: fmul_mant_iter

Overview:
- Iterative shift-and-add unsigned mantissa multiplier for the F_Mul path; computes the 2*MANT_W-bit significand product.
- Sits directly upstream of the 64-bit carry-lookahead adder and drives its operands every cycle.
- Consumes the adder's sum/carry back into an internal accumulator. The adder is instantiated by the parent (cin tied 0); this block owns only control and registers.
- Valid/ready handshakes on both sides; one operation in flight.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; legal 2..32.
- ACC_W, 64, accumulator/adder width; must equal adder width; 2*MANT_W <= ACC_W required.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (IDLE only)
- in_mcand  input  MANT_W  multiplicand mantissa
- in_mplier  input  MANT_W  multiplier mantissa
- add_op1  output  ACC_W  adder operand 1 = accumulator register
- add_op2  output  ACC_W  adder operand 2 = shifted-multiplicand register
- add_sum  input  ACC_W  adder sum (combinational return)
- add_cout  input  1  adder carry-out
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_prod  output  2*MANT_W  product = acc[2*MANT_W-1:0]
- out_ovf  output  1  sticky: an accepted add produced add_cout=1 or nonzero acc[ACC_W-1:2*MANT_W]; 0 for legal operands

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; acc, mcand_sh, mplier_sh, cnt, ovf cleared. Outputs after reset: in_ready=1, out_valid=0, out_prod=0, out_ovf=0, add_op1=0, add_op2=0. Reset overrides every other event, including mid-RUN or in DONE; any in-flight result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: acc<=0; mcand_sh<=zero-extended in_mcand; mplier_sh<=in_mplier; cnt<=0; ovf<=0; go to RUN.
  - Operand values are ignored when in_valid=0.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - If mplier_sh[0]=1: acc<=add_sum and ovf<=ovf|add_cout. Otherwise acc holds and add_sum is ignored.
  - mcand_sh<=mcand_sh<<1 (zero fill, MSB discarded); mplier_sh<=mplier_sh>>1; cnt<=cnt+1.
  - When cnt==MANT_W-1 at the edge, go to DONE.
  - Iteration count is always exactly MANT_W; there is no early exit on zero multiplier.
- Latency: accept edge at T; MANT_W RUN edges T+1..T+MANT_W; out_valid=1 in the cycle after edge T+MANT_W. Total latency is MANT_W+1 cycles from accept to out_valid.
- DONE: out_valid=1; out_prod, out_ovf and acc held stable while out_ready=0 (no value change under backpressure).
  - On out_valid&out_ready: go to IDLE; in_ready=1 next cycle.
  - Entering DONE: ovf<=ovf | (|acc_next[ACC_W-1:2*MANT_W]).
- No overlap: a new operand is accepted at earliest one cycle after the output handshake, so back-to-back throughput is one product per MANT_W+2 cycles.
- add_op1/add_op2 are driven purely from registers (no combinational path from inputs). The adder is used combinationally in the same cycle.
- out_prod and out_ovf retain the last value in IDLE until the next result overwrites them in DONE; only out_valid qualifies them.
- Width rules: mcand_sh is ACC_W bits; the multiplier shift register is MANT_W bits; cnt is clog2(MANT_W)+1 bits; unsigned arithmetic throughout.

Test Plan:
- 0x800000 x 0x800000 (1.0 x 1.0), out_ready=1 → out_valid exactly 25 cycles after accept; out_prod=0x400000000000; out_ovf=0; in_ready=1 the following cycle.
- 0xFFFFFF x 0xFFFFFF → out_prod=0xFFFFFE000001; out_ovf=0; add_op2 observed doubling each RUN cycle (0xFFFFFF, 0x1FFFFFE, …).
- 0xC00000 x 0x000000 → out_prod=0; acc never updates in RUN (add_sum forced to garbage by bench has no effect); latency still 25.
- Backpressure: 0xA00000 x 0xC00000, out_ready=0 for 10 cycles after out_valid → out_prod=0x780000000000 held stable, in_ready=0 throughout; completes on out_ready=1.
- Reset mid-operation: rst=1 at RUN cycle 12 → next cycle in_ready=1, out_valid=0, add_op1=0; new op 0x900000 x 0x800000 then yields 0x480000000000.
- Bench-forced add_cout=1 on one active add → out_ovf=1 with out_valid; cleared on next accept.
